io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
Memory-mapped IO responder on the IO region (address[15:14]=11) of the CPU memory controller. It takes the controller's IO write-enable, 14-bit address and 8-bit write data, and returns 8-bit read data.
- Holds LED output, synchronized switch input, sticky button-edge flags and an 8-bit prescaled countdown timer with an interrupt line.
- Read data is registered, giving one-cycle read latency, the same as the dataRAM and stack blocks.

Parameters:
PRESCALE, 50000, clk cycles per timer tick (must be >= 1)
NUM_BTN, 4, number of button inputs (1..8)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
wrEn  in  1  IO write enable from the memory controller
addr  in  14  word address within the IO region; only addr[3:0] are decoded
wrData  in  8  write data from the memory controller
rdData  out  8  registered read data to the memory controller
sw_in  in  8  raw asynchronous switch inputs
btn_in  in  NUM_BTN  raw asynchronous button inputs, active-high
led_out  out  8  LED register contents
timer_irq  out  1  level output, equal to the timer expired flag

Behaviour:
- Reset (synchronous, active-high) clears: all registers, sync flops, prescaler, count, flags; rdData=0, led_out=0, timer_irq=0.
- Register map (addr[3:0]); undecoded addresses, and addr[13:4] != 0, read 0 and ignore writes:
  - 0x0 LED, RW.
  - 0x1 SW, RO; two-flop synchronized sw_in.
  - 0x2 BTN, R/W1C; bit i sets on a rising edge of the two-flop-synced btn_in[i] (third flop used for edge detect).
  - 0x3 CTRL, RW; bit0 EN, bit1 AUTO; other bits read 0.
  - 0x4 RELOAD, RW.
  - 0x5 COUNT, RO.
  - 0x6 STATUS, R/W1C; bit0 EXPIRED.
- Reads:
  - rdData <= mux(addr) every cycle, regardless of wrEn.
  - Data is valid the cycle after addr is presented.
  - A write to a register and a read of it in the same cycle return the old value.
- Writes take effect at the clock edge where wrEn=1.
- W1C conflicts: a set event (button edge, timer expiry) and a W1C clear of the same bit in the same cycle leave the bit set (set wins).
- Timer prescaler:
  - Counts 0..PRESCALE-1 while EN=1; the tick pulse occurs on wrap.
  - Held at 0 while EN=0.
- CTRL write with EN 0->1 loads COUNT<=RELOAD and clears the prescaler.
- CTRL write with EN=1 while EN is already 1 leaves COUNT and prescaler untouched.
- On a tick with COUNT>0: COUNT<=COUNT-1.
- On a tick with COUNT==0:
  - EXPIRED<=1.
  - If AUTO=1: COUNT<=RELOAD.
  - If AUTO=0: EN<=0 and COUNT stays 0.
- RELOAD=0 with AUTO=1 makes EXPIRED assert on every tick.
- A CTRL write in the same cycle as a hardware EN clear: the write wins.
- Reset mid-count: everything returns to reset values on the next edge; no partial tick survives.

Decomposition:
- Shared package holds:
  - Register address constants (IO_LED=4'h0 .. IO_STATUS=4'h6).
  - CTRL bit positions (CTRL_EN=0, CTRL_AUTO=1).
  - Region select constant IO_REGION=2'b11.
- One sub-module, io_sync_edge: parameterized-width two-flop synchronizer plus rising-edge pulse output. Used for btn_in; sw_in uses its synchronized output only.

Test Plan:
- Reset check: assert reset 2 cycles, then read each of 0x0..0x6 -> rdData=0x00 one cycle after each addr; led_out=0; timer_irq=0.
- LED and unmapped writes:
  - Write 0xA5 to 0x0 -> led_out=0xA5 next cycle; read 0x0 -> 0xA5.
  - Write 0xFF to 0x7 -> no register changes; read 0x7 -> 0x00.
- Switch sync: set sw_in=0x3C -> read 0x1 returns 0x3C no earlier than 3 cycles after the change (2 sync + 1 read register).
- Button edge flags:
  - Pulse btn_in[2] high for 5 cycles -> read 0x2 = 0x04, and it stays 0x04 after release.
  - Write 0x04 to 0x2 -> reads 0x00.
  - Edge arriving in the same cycle as the W1C -> bit remains set.
- One-shot timer (PRESCALE=4, RELOAD=3, write CTRL=0x01):
  - COUNT steps 3,2,1,0, one step per 4 cycles.
  - Next tick -> EXPIRED=1, timer_irq=1, CTRL reads 0x00, COUNT=0.
  - Write 0x01 to 0x6 -> timer_irq=0.
- Auto-reload timer (PRESCALE=4, RELOAD=1, CTRL=0x03):
  - EXPIRED sets every 8 cycles while COUNT cycles 1,0,1,0.
  - Assert reset mid-count -> COUNT=0, CTRL=0, timer_irq=0 next cycle.

Source files
------------

// File: rtl/io_port_responder_pkg.sv
// Shared definitions for the IO-region responder: register offsets, CTRL bit layout.
// Latency: n/a (constants and a pure decode helper only).
// Backpressure: n/a.
package io_port_responder_pkg;

  // Region select on the full CPU address; the controller decodes it before us.
  localparam logic [1:0] IO_REGION = 2'b11;

  // Register offsets within the IO region (addr[3:0]).
  localparam logic [3:0] IO_LED     = 4'h0;
  localparam logic [3:0] IO_SW      = 4'h1;
  localparam logic [3:0] IO_BTN     = 4'h2;
  localparam logic [3:0] IO_CTRL    = 4'h3;
  localparam logic [3:0] IO_RELOAD  = 4'h4;
  localparam logic [3:0] IO_COUNT   = 4'h5;
  localparam logic [3:0] IO_STATUS  = 4'h6;

  // CTRL and STATUS bit positions.
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int STATUS_EXPIRED = 0;

  // Only the low 16 words of the region are populated; anything above aliases nothing.
  function automatic logic io_offset_ok(input logic [13:0] a);
    return (a[13:4] == 10'd0);
  endfunction

endpackage

// File: rtl/io_port_responder_sync_edge.sv
// Two-flop synchronizer for asynchronous inputs plus a rising-edge pulse from a third flop.
// Latency: o_sync follows i_async after 2 edges; o_rise is high for the cycle after o_sync rises.
// Backpressure: none; free-running every cycle.
module io_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  // Metastability chain; r_s3 only holds the previous synced level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped IO responder: LEDs, synced switches, sticky button edges, prescaled countdown timer.
// Latency: read data registered, valid one cycle after addr; writes take effect at the wrEn edge.
// Backpressure: none; every access completes in one cycle, no stall path to the controller.
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int NUM_BTN  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wrEn,
  input  logic [13:0]        addr,
  input  logic [7:0]         wrData,
  output logic [7:0]         rdData,
  input  logic [7:0]         sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [7:0]         led_out,
  output logic               timer_irq
);

  // A PRESCALE of 1 still needs a 1-bit counter; it simply wraps every cycle.
  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  // ---------------------------------------------------------------- decode
  logic       w_local;
  logic [3:0] w_reg;
  logic       w_wr;
  logic       w_wr_led;
  logic       w_wr_btn;
  logic       w_wr_ctrl;
  logic       w_wr_reload;
  logic       w_wr_status;

  assign w_local     = io_offset_ok(addr);
  assign w_reg       = addr[3:0];
  assign w_wr        = wrEn && w_local;
  assign w_wr_led    = w_wr && (w_reg == IO_LED);
  assign w_wr_btn    = w_wr && (w_reg == IO_BTN);
  assign w_wr_ctrl   = w_wr && (w_reg == IO_CTRL);
  assign w_wr_reload = w_wr && (w_reg == IO_RELOAD);
  assign w_wr_status = w_wr && (w_reg == IO_STATUS);

  // ---------------------------------------------------------------- inputs
  logic [7:0]         r_sw_s1;
  logic [7:0]         r_sw_s2;
  logic [NUM_BTN-1:0] w_btn_sync;
  logic [NUM_BTN-1:0] w_btn_rise;
  logic [NUM_BTN-1:0] r_btn_flags;

  // Switches are level-only, so a plain two-flop synchronizer is enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw_in;
      r_sw_s2 <= r_sw_s1;
    end
  end

  io_sync_edge #(
    .W (NUM_BTN)
  ) u_btn_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (btn_in),
    .o_sync  (w_btn_sync),
    .o_rise  (w_btn_rise)
  );

  // Sticky button-edge flags; a fresh edge beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_flags <= '0;
    end else if (w_wr_btn) begin
      r_btn_flags <= (r_btn_flags & ~wrData[NUM_BTN-1:0]) | w_btn_rise;
    end else begin
      r_btn_flags <= r_btn_flags | w_btn_rise;
    end
  end

  // ---------------------------------------------------------------- LED
  logic [7:0] r_led;

  // Plain read/write output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led <= wrData;
    end
  end

  assign led_out = r_led;

  // ---------------------------------------------------------------- timer
  logic          r_en;
  logic          r_auto;
  logic [7:0]    r_reload;
  logic [7:0]    r_count;
  logic          r_expired;
  logic [PW-1:0] r_presc;

  logic w_new_en;
  logic w_en_start;
  logic w_tick;
  logic w_zero_tick;

  assign w_new_en    = wrData[CTRL_EN];
  assign w_en_start  = w_wr_ctrl && w_new_en && !r_en;
  assign w_tick      = r_en && (r_presc == PRESC_MAX);
  assign w_zero_tick = w_tick && (r_count == 8'd0);

  // Prescaler: runs only while enabled, restarts on an EN 0->1 write, idles at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_en_start || !r_en || (w_wr_ctrl && !w_new_en)) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // CTRL: a software write always overrides the one-shot hardware EN clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_auto <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= w_new_en;
      r_auto <= wrData[CTRL_AUTO];
    end else if (w_zero_tick && !r_auto) begin
      r_en   <= 1'b0;
    end
  end

  // RELOAD register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload <= '0;
    end else if (w_wr_reload) begin
      r_reload <= wrData;
    end
  end

  // COUNT: load on enable, decrement per tick, reload (auto) or hold at 0 (one-shot) on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_en_start) begin
      r_count <= r_reload;
    end else if (w_tick) begin
      if (r_count != 8'd0) begin
        r_count <= r_count - 8'd1;
      end else if (r_auto) begin
        r_count <= r_reload;
      end
    end
  end

  // EXPIRED: set by a tick at zero, cleared by write-1; the set wins a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_expired <= 1'b0;
    end else if (w_zero_tick) begin
      r_expired <= 1'b1;
    end else if (w_wr_status && wrData[STATUS_EXPIRED]) begin
      r_expired <= 1'b0;
    end
  end

  assign timer_irq = r_expired;

  // ---------------------------------------------------------------- read path
  logic [7:0] w_btn_rd;
  logic [7:0] w_ctrl_rd;
  logic [7:0] w_rd_mux;

  // Zero-extend the button flags to the 8-bit data bus for any NUM_BTN up to 8.
  always_comb begin
    w_btn_rd                = '0;
    w_btn_rd[NUM_BTN-1:0]   = r_btn_flags;
    w_ctrl_rd               = '0;
    w_ctrl_rd[CTRL_EN]      = r_en;
    w_ctrl_rd[CTRL_AUTO]    = r_auto;
  end

  // Register select; unmapped offsets and out-of-window addresses read as zero.
  always_comb begin
    w_rd_mux = '0;
    if (w_local) begin
      case (w_reg)
        IO_LED:    w_rd_mux = r_led;
        IO_SW:     w_rd_mux = r_sw_s2;
        IO_BTN:    w_rd_mux = w_btn_rd;
        IO_CTRL:   w_rd_mux = w_ctrl_rd;
        IO_RELOAD: w_rd_mux = r_reload;
        IO_COUNT:  w_rd_mux = r_count;
        IO_STATUS: w_rd_mux = {7'd0, r_expired};
        default:   w_rd_mux = '0;
      endcase
    end
  end

  // Read data sampled every cycle from pre-edge state, so a same-cycle write returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdData <= '0;
    end else begin
      rdData <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with a short prescaler so timer behaviour is quick to reach.
// Latency: inputs driven on falling edges; each read is checked one full cycle after addr.
// Backpressure: n/a; a free-running watchdog bounds the run.
module tb_io_port_responder;

  logic        clk;
  logic        reset;
  logic        wrEn;
  logic [13:0] addr;
  logic [7:0]  wrData;
  logic [7:0]  rdData;
  logic [7:0]  sw_in;
  logic [3:0]  btn_in;
  logic [7:0]  led_out;
  logic        timer_irq;

  int n_chk  = 0;
  int n_fail = 0;

  io_port_responder #(
    .PRESCALE (4),
    .NUM_BTN  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wrEn      (wrEn),
    .addr      (addr),
    .wrData    (wrData),
    .rdData    (rdData),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks enter and leave just after a falling edge; each consumes whole cycles.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    addr   = a;
    wrData = d;
    wrEn   = 1'b1;
    @(negedge clk);
    wrEn   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [7:0] exp);
    addr = a;
    wrEn = 1'b0;
    @(negedge clk);
    chk(tag, rdData, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    wrEn   = 1'b0;
    addr   = '0;
    wrData = '0;
    sw_in  = '0;
    btn_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    for (int i = 0; i <= 6; i++) begin
      rd($sformatf("reset_rd_%0d", i), 14'(i), 8'h00);
    end
    chk("reset_led", led_out, 8'h00);
    chk("reset_irq", timer_irq, 1'b0);

    // LED and unmapped writes
    wr(14'h0000, 8'hA5);
    chk("led_out", led_out, 8'hA5);
    rd("led_rd", 14'h0000, 8'hA5);
    wr(14'h0007, 8'hFF);
    rd("unmapped_rd", 14'h0007, 8'h00);
    wr(14'h0010, 8'h11);
    rd("hi_addr_rd", 14'h0010, 8'h00);
    rd("led_kept", 14'h0000, 8'hA5);
    chk("led_out_kept", led_out, 8'hA5);

    // Switch synchronizer: value appears on the third read edge after the change
    sw_in = 8'h3C;
    rd("sw_lat1", 14'h0001, 8'h00);
    rd("sw_lat2", 14'h0001, 8'h00);
    rd("sw_lat3", 14'h0001, 8'h3C);

    // Button edge flags
    btn_in = 4'b0100;
    cycles(5);
    btn_in = 4'b0000;
    rd("btn_set", 14'h0002, 8'h04);
    cycles(3);
    rd("btn_sticky", 14'h0002, 8'h04);
    wr(14'h0002, 8'h04);
    rd("btn_w1c", 14'h0002, 8'h00);
    // Edge lands on the same edge as the W1C: rise visible two edges after the input change
    btn_in = 4'b0100;
    cycles(2);
    wr(14'h0002, 8'h04);
    rd("btn_set_wins", 14'h0002, 8'h04);
    wr(14'h0002, 8'h04);
    rd("btn_cleared", 14'h0002, 8'h00);
    btn_in = 4'b0000;
    cycles(3);

    // One-shot timer: RELOAD=3, tick every 4 cycles
    wr(14'h0004, 8'h03);
    rd("reload_rd", 14'h0004, 8'h03);
    wr(14'h0003, 8'h01);
    for (int s = 0; s < 4; s++) begin
      rd($sformatf("oneshot_count_%0d", s), 14'h0005, 8'(3 - s));
      chk($sformatf("oneshot_irq_lo_%0d", s), timer_irq, 1'b0);
      cycles(3);
    end
    chk("oneshot_irq", timer_irq, 1'b1);
    rd("oneshot_ctrl", 14'h0003, 8'h00);
    rd("oneshot_count_end", 14'h0005, 8'h00);
    rd("oneshot_status", 14'h0006, 8'h01);
    wr(14'h0006, 8'h01);
    chk("oneshot_irq_clr", timer_irq, 1'b0);

    // Auto-reload timer: RELOAD=1, expiry every 8 cycles
    wr(14'h0004, 8'h01);
    wr(14'h0003, 8'h03);
    cycles(7);
    chk("auto_irq_pre", timer_irq, 1'b0);
    cycles(1);
    chk("auto_irq_1", timer_irq, 1'b1);
    rd("auto_count_reload", 14'h0005, 8'h01);
    wr(14'h0006, 8'h01);
    chk("auto_irq_clr", timer_irq, 1'b0);
    cycles(5);
    chk("auto_irq_pre2", timer_irq, 1'b0);
    cycles(1);
    chk("auto_irq_2", timer_irq, 1'b1);
    rd("auto_ctrl", 14'h0003, 8'h03);
    cycles(6);
    wr(14'h0006, 8'h01);
    chk("auto_set_wins", timer_irq, 1'b1);

    // Reset mid-count
    cycles(1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_irq", timer_irq, 1'b0);
    chk("rst_led", led_out, 8'h00);
    rd("rst_count", 14'h0005, 8'h00);
    rd("rst_ctrl", 14'h0003, 8'h00);
    rd("rst_reload", 14'h0004, 8'h00);

    // RELOAD=0 with AUTO: expiry on every tick
    wr(14'h0003, 8'h03);
    cycles(3);
    chk("r0_irq_pre", timer_irq, 1'b0);
    cycles(1);
    chk("r0_irq_1", timer_irq, 1'b1);
    wr(14'h0006, 8'h01);
    chk("r0_irq_clr", timer_irq, 1'b0);
    cycles(2);
    chk("r0_irq_pre2", timer_irq, 1'b0);
    cycles(1);
    chk("r0_irq_2", timer_irq, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
